// File: rtl/rr_arb_mux.sv
// N-channel registered multiplexer with valid/ready handshaking.
// Selects one channel per cycle by explicit address or round-robin, held in a one-entry output register.
module rr_arb_mux #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        address,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam logic [SEL_W:0] NUM_IN_W = (SEL_W+1)'(NUM_IN);

  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             vld_q, vld_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

  logic             load_en;
  logic [SEL_W-1:0] grant;
  logic             grant_ok;
  logic [SEL_W:0]   idx;
  logic [WIDTH-1:0] sel_data;

  assign load_en = !vld_q | out_ready;

  // Addressed mode only matches in-range channels, so an out-of-range address never grants.
  always_comb begin
    grant    = '0;
    grant_ok = 1'b0;
    idx      = '0;
    if (!mode) begin
      grant = address;
      for (int i = 0; i < NUM_IN; i++) begin
        if (address == SEL_W'(i) && in_valid[i]) grant_ok = 1'b1;
      end
    end else begin
      for (int k = 0; k < NUM_IN; k++) begin
        idx = {1'b0, rr_ptr_q} + (SEL_W+1)'(k);
        if (idx >= NUM_IN_W) idx = idx - NUM_IN_W;
        if (!grant_ok && in_valid[idx[SEL_W-1:0]]) begin
          grant    = idx[SEL_W-1:0];
          grant_ok = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant == SEL_W'(i)) sel_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      in_ready[i] = !reset & load_en & grant_ok & (grant == SEL_W'(i));
    end
  end

  always_comb begin
    data_d   = data_q;
    sel_d    = sel_q;
    vld_d    = vld_q;
    rr_ptr_d = rr_ptr_q;
    if (load_en) begin
      if (grant_ok) begin
        data_d   = sel_data;
        sel_d    = grant;
        vld_d    = 1'b1;
        rr_ptr_d = ({1'b0, grant} == NUM_IN_W - 1'b1) ? '0 : grant + 1'b1;
      end else begin
        vld_d = 1'b0;
      end
    end
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q   <= '0;
      sel_q    <= '0;
      vld_q    <= 1'b0;
      rr_ptr_q <= '0;
    end else begin
      data_q   <= data_d;
      sel_q    <= sel_d;
      vld_q    <= vld_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign out_data  = data_q;
  assign out_sel   = sel_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: a 4-channel and a 3-channel instance share stimulus and are
// checked against directed vectors plus a queue-free behavioural model.
module tb_rr_arb_mux;

  logic         clk = 1'b0;
  logic         reset;
  logic         mode;
  logic [1:0]   address;
  logic [127:0] in_data;
  logic [3:0]   in_valid;
  logic         out_ready;

  logic [3:0]  rdy4;
  logic [31:0] od4;
  logic [1:0]  os4;
  logic        ov4;
  logic [2:0]  rdy3;
  logic [31:0] od3;
  logic [1:0]  os3;
  logic        ov3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rr_arb_mux #(.WIDTH(32), .NUM_IN(4)) dut4 (
    .clk(clk), .reset(reset), .mode(mode), .address(address),
    .in_data(in_data), .in_valid(in_valid), .in_ready(rdy4),
    .out_data(od4), .out_sel(os4), .out_valid(ov4), .out_ready(out_ready));

  rr_arb_mux #(.WIDTH(32), .NUM_IN(3)) dut3 (
    .clk(clk), .reset(reset), .mode(mode), .address(address),
    .in_data(in_data[95:0]), .in_valid(in_valid[2:0]), .in_ready(rdy3),
    .out_data(od3), .out_sel(os3), .out_valid(ov3), .out_ready(out_ready));

  // Reference model state, index 0 = 4-channel, index 1 = 3-channel
  int          nn[2] = '{4, 3};
  bit          mv[2];
  logic [31:0] md[2];
  int          ms[2];
  int          mp[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input int n, input int ptr, output bit ok);
    ok = 1'b0;
    if (!mode) begin
      ok = (int'(address) < n) && in_valid[address];
      return int'(address);
    end
    for (int k = 0; k < n; k++) begin
      int c;
      c = (ptr + k) % n;
      if (in_valid[c]) begin
        ok = 1'b1;
        return c;
      end
    end
    return 0;
  endfunction

  function automatic logic [3:0] exp_rdy(input int j);
    bit ok;
    int g;
    g = pick(nn[j], mp[j], ok);
    if (reset) return 4'b0;
    if ((!mv[j] || out_ready) && ok) return 4'(1 << g);
    return 4'b0;
  endfunction

  task automatic model_update();
    for (int j = 0; j < 2; j++) begin
      bit ok;
      int g;
      g = pick(nn[j], mp[j], ok);
      if (reset) begin
        mv[j] = 0; md[j] = 0; ms[j] = 0; mp[j] = 0;
      end else if (!mv[j] || out_ready) begin
        if (ok) begin
          mv[j] = 1;
          md[j] = in_data[g*32 +: 32];
          ms[j] = g;
          mp[j] = (g + 1) % nn[j];
        end else begin
          mv[j] = 0;
        end
      end
    end
  endtask

  // Inputs are already driven after a negedge; check, clock, check outputs at next negedge.
  task automatic step();
    #1;
    chk("rdy4_model", {28'b0, rdy4}, {28'b0, exp_rdy(0)});
    chk("rdy3_model", {29'b0, rdy3}, {28'b0, exp_rdy(1)});
    @(posedge clk);
    model_update();
    @(negedge clk);
    chk("ov4_model", {31'b0, ov4}, {31'b0, mv[0]});
    chk("os4_model", {30'b0, os4}, 32'(ms[0]));
    chk("od4_model", od4, md[0]);
    chk("ov3_model", {31'b0, ov3}, {31'b0, mv[1]});
    chk("os3_model", {30'b0, os3}, 32'(ms[1]));
    chk("od3_model", od3, md[1]);
  endtask

  typedef struct {
    bit          rst;
    bit          md;
    logic [1:0]  addr;
    logic [3:0]  vld;
    bit          ordy;
    logic [3:0]  e_rdy;
    bit          e_ov;
    logic [1:0]  e_os;
    logic [31:0] e_od;
  } vec_t;

  localparam logic [31:0] D0 = 32'h1000_0000;
  localparam logic [31:0] D1 = 32'h1111_1111;
  localparam logic [31:0] D2 = 32'hDEAD_BEEF;
  localparam logic [31:0] D3 = 32'h3333_3333;

  vec_t vt[19];

  initial begin
    vt[0]  = '{1, 0, 2'd0, 4'b1111, 1, 4'b0000, 0, 2'd0, 32'h0};
    vt[1]  = '{1, 0, 2'd0, 4'b1111, 1, 4'b0000, 0, 2'd0, 32'h0};
    vt[2]  = '{0, 0, 2'd2, 4'b0100, 1, 4'b0100, 1, 2'd2, D2};
    vt[3]  = '{0, 0, 2'd3, 4'b0100, 1, 4'b0000, 0, 2'd2, D2};
    vt[4]  = '{1, 0, 2'd0, 4'b0000, 1, 4'b0000, 0, 2'd0, 32'h0};
    vt[5]  = '{0, 1, 2'd0, 4'b1111, 1, 4'b0001, 1, 2'd0, D0};
    vt[6]  = '{0, 1, 2'd0, 4'b1111, 1, 4'b0010, 1, 2'd1, D1};
    vt[7]  = '{0, 1, 2'd0, 4'b1111, 1, 4'b0100, 1, 2'd2, D2};
    vt[8]  = '{0, 1, 2'd0, 4'b1111, 1, 4'b1000, 1, 2'd3, D3};
    vt[9]  = '{0, 1, 2'd0, 4'b1111, 1, 4'b0001, 1, 2'd0, D0};
    vt[10] = '{0, 1, 2'd0, 4'b1111, 1, 4'b0010, 1, 2'd1, D1};
    vt[11] = '{0, 1, 2'd0, 4'b1111, 1, 4'b0100, 1, 2'd2, D2};
    vt[12] = '{0, 1, 2'd0, 4'b1111, 1, 4'b1000, 1, 2'd3, D3};
    vt[13] = '{0, 1, 2'd0, 4'b0010, 0, 4'b0000, 1, 2'd3, D3};
    vt[14] = '{0, 1, 2'd0, 4'b0010, 0, 4'b0000, 1, 2'd3, D3};
    vt[15] = '{0, 1, 2'd0, 4'b0010, 0, 4'b0000, 1, 2'd3, D3};
    vt[16] = '{0, 1, 2'd0, 4'b0010, 1, 4'b0010, 1, 2'd1, D1};
    vt[17] = '{1, 1, 2'd0, 4'b1111, 0, 4'b0000, 0, 2'd0, 32'h0};
    vt[18] = '{0, 1, 2'd0, 4'b1010, 0, 4'b0010, 1, 2'd1, D1};

    for (int j = 0; j < 2; j++) begin
      mv[j] = 0; md[j] = 0; ms[j] = 0; mp[j] = 0;
    end
    reset = 1; mode = 0; address = 0; in_valid = 0; out_ready = 0;
    in_data = {D3, D2, D1, D0};
    @(negedge clk);

    for (int i = 0; i < 19; i++) begin
      reset = vt[i].rst; mode = vt[i].md; address = vt[i].addr;
      in_valid = vt[i].vld; out_ready = vt[i].ordy;
      #1;
      chk($sformatf("vec%0d_rdy", i), {28'b0, rdy4}, {28'b0, vt[i].e_rdy});
      step();
      chk($sformatf("vec%0d_ov", i), {31'b0, ov4}, {31'b0, vt[i].e_ov});
      chk($sformatf("vec%0d_os", i), {30'b0, os4}, {30'b0, vt[i].e_os});
      chk($sformatf("vec%0d_od", i), od4, vt[i].e_od);
    end

    // Three-channel wrap: set rr_ptr=1 via an addressed grant of ch0, then scan from 1.
    reset = 1; out_ready = 1; in_valid = 4'b0000; step();
    reset = 0; mode = 0; address = 0; in_valid = 4'b0001; step();
    chk("w3_first_sel", {30'b0, os3}, 32'd0);
    mode = 1; in_valid = 4'b0101; step();
    chk("w3_ch2_sel", {30'b0, os3}, 32'd2);
    chk("w3_ch2_data", od3, D2);
    step();
    chk("w3_wrap_sel", {30'b0, os3}, 32'd0);
    chk("w3_wrap_vld", {31'b0, ov3}, 32'd1);
    mode = 0; address = 3; in_valid = 4'b0111;
    #1;
    chk("w3_addr3_rdy", {29'b0, rdy3}, 32'd0);
    step();
    chk("w3_addr3_vld", {31'b0, ov3}, 32'd0);
    chk("w3_addr3_hold", {30'b0, os3}, 32'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 63) == 0);
      mode      = 1'($urandom_range(0, 1));
      address   = 2'($urandom_range(0, 3));
      in_valid  = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
